// File: rtl/cpu_defs.sv
// Shared CPU definitions: default widths, opcode constants, instruction field
// positions and the fetch-stage state encoding. control_unit_M decodes with
// the same opcode constants.
package cpu_defs;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int RS_LSB  = 8;
  localparam int RT_LSB  = 4;
  localparam int RD_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 8;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_VALID  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, load has priority
// over increment, increment wraps modulo 2^PC_W.
module pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // Update the PC: reset, redirect load, or step to the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads over a ready handshake, latches
// the returned word into the instruction register, presents its fields via
// valid/ready, follows branch redirects and stops on HALT.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [3:0]         id_opcode,
  output logic [3:0]         id_rs,
  output logic [3:0]         id_rt,
  output logic [3:0]         id_rd,
  output logic [7:0]         id_imm,
  output logic [PC_W-1:0]    id_pc,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               halted
);

  fetch_state_t        state, next_state;
  logic                started;
  logic [INSTR_W-1:0]  ir;
  logic [PC_W-1:0]     pc;
  logic                redir_pend;
  logic [PC_W-1:0]     redir_tgt;
  logic                pc_inc, pc_load, ir_load, pend_set, pend_clr;
  logic [PC_W-1:0]     pc_load_val;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  assign imem_addr = pc;
  assign id_opcode = ir[OPC_LSB +: REG_W];
  assign id_rs     = ir[RS_LSB  +: REG_W];
  assign id_rt     = ir[RT_LSB  +: REG_W];
  assign id_rd     = ir[RD_LSB  +: REG_W];
  assign id_imm    = ir[IMM_LSB +: IMM_W];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next state, handshake outputs and datapath controls. 'started' holds off
  // the request for the first cycle after reset so a held-over ready is ignored.
  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    id_valid    = 1'b0;
    halted      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = br_target;
    ir_load     = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = started;
        if (started) begin
          if (imem_ready) begin
            if (redir_pend || br_taken) begin
              pc_load     = 1'b1;
              pc_load_val = br_taken ? br_target : redir_tgt;
              pend_clr    = 1'b1;
            end else begin
              ir_load    = 1'b1;
              pc_inc     = 1'b1;
              next_state = ST_VALID;
            end
          end else if (br_taken) begin
            pend_set = 1'b1;
          end
        end
      end
      ST_VALID: begin
        id_valid = 1'b1;
        if (br_taken) begin
          pc_load    = 1'b1;
          next_state = ST_FETCH;
        end else if (id_ready) begin
          next_state = (id_opcode == HALT_OP) ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase
  end

  // Instruction register, presented PC and the pending-redirect latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      started    <= 1'b0;
      ir         <= '0;
      id_pc      <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else begin
      started <= 1'b1;
      if (ir_load) begin
        ir    <= imem_rdata;
        id_pc <= pc;
      end
      if (pend_set) begin
        redir_pend <= 1'b1;
        redir_tgt  <= br_target;
      end else if (pend_clr) begin
        redir_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A transaction-level model tracks
// the next fetch address, the last loaded word and the presented PC; the
// memory is a plain array.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [7:0]  imemAddr;
  logic [15:0] imemRdata;
  logic        imemReady;
  logic        idValid;
  logic        idReady;
  logic [3:0]  idOpcode, idRs, idRt, idRd;
  logic [7:0]  idImm;
  logic [7:0]  idPc;
  logic        brTaken;
  logic [7:0]  brTarget;
  logic        halted;

  logic [15:0] mem [256];
  int          modelPc;
  logic [15:0] modelIr;
  int          modelIdPc;
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imemReq),
    .imem_addr  (imemAddr),
    .imem_rdata (imemRdata),
    .imem_ready (imemReady),
    .id_valid   (idValid),
    .id_ready   (idReady),
    .id_opcode  (idOpcode),
    .id_rs      (idRs),
    .id_rt      (idRt),
    .id_rd      (idRd),
    .id_imm     (idImm),
    .id_pc      (idPc),
    .br_taken   (brTaken),
    .br_target  (brTarget),
    .halted     (halted)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkFields(input string tag, input logic [15:0] word);
    int w;
    w = int'(word);
    checkOutput({tag, "_opcode"}, 16'(idOpcode), 16'((w >> 12) % 16));
    checkOutput({tag, "_rs"},     16'(idRs),     16'((w >> 8) % 16));
    checkOutput({tag, "_rt"},     16'(idRt),     16'((w >> 4) % 16));
    checkOutput({tag, "_rd"},     16'(idRd),     16'(w % 16));
    checkOutput({tag, "_imm"},    16'(idImm),    16'(w % 256));
  endtask

  task automatic resetDut();
    rst = 1'b1; imemReady = 1'b0; idReady = 1'b0; brTaken = 1'b0;
    tick(); tick();
    checkOutput("rst_req",    16'(imemReq), 16'd0);
    checkOutput("rst_valid",  16'(idValid), 16'd0);
    checkOutput("rst_halted", 16'(halted),  16'd0);
    checkOutput("rst_idpc",   16'(idPc),    16'd0);
    checkOutput("rst_ir",     16'(idOpcode), 16'd0);
    rst = 1'b0;
    modelPc = 0; modelIr = 16'h0; modelIdPc = 0;
    tick();
    checkOutput("first_req",  16'(imemReq),  16'd1);
    checkOutput("first_addr", 16'(imemAddr), 16'd0);
  endtask

  // One memory transaction: waitCycles of not-ready, then ready. Branch pulses
  // at cycle indices brA/brB (-1 = none); the last pulse's target wins.
  task automatic fetchStep(input int waitCycles, input int brA, input logic [7:0] tgtA,
                           input int brB, input logic [7:0] tgtB, output bit dropped);
    bit         anyBr;
    logic [7:0] finalTgt;
    logic [15:0] word;
    anyBr = 1'b0; finalTgt = 8'h0;
    checkOutput("req_issued", 16'(imemReq),  16'd1);
    checkOutput("fetch_addr", 16'(imemAddr), 16'(modelPc));
    for (int k = 0; k <= waitCycles; k++) begin
      imemReady = (k == waitCycles);
      imemRdata = imemReady ? mem[modelPc] : 16'hDEAD;
      brTaken   = (k == brA) || (k == brB);
      brTarget  = (k == brB) ? tgtB : tgtA;
      if (brTaken) begin
        anyBr = 1'b1;
        finalTgt = brTarget;
      end
      tick();
      brTaken = 1'b0; imemReady = 1'b0;
      if (k < waitCycles) begin
        checkOutput("wait_req",    16'(imemReq),  16'd1);
        checkOutput("wait_addr",   16'(imemAddr), 16'(modelPc));
        checkOutput("wait_valid",  16'(idValid),  16'd0);
        checkOutput("wait_ir",     16'(idOpcode), 16'(int'(modelIr) >> 12));
      end
    end
    if (anyBr) begin
      checkOutput("drop_valid", 16'(idValid),  16'd0);
      checkOutput("drop_req",   16'(imemReq),  16'd1);
      checkOutput("drop_addr",  16'(imemAddr), 16'(finalTgt));
      modelPc = int'(finalTgt);
      dropped = 1'b1;
    end else begin
      word = mem[modelPc];
      checkOutput("got_valid", 16'(idValid), 16'd1);
      checkOutput("got_idpc",  16'(idPc),    16'(modelPc));
      checkFields("got", word);
      modelIr   = word;
      modelIdPc = modelPc;
      modelPc   = (modelPc + 1) % 256;
      dropped   = 1'b0;
    end
  endtask

  // Downstream holds id_ready low for stall cycles, then accepts (optionally
  // together with a redirect).
  task automatic acceptStep(input int stall, input bit branch, input logic [7:0] tgt);
    checkOutput("pre_accept_valid", 16'(idValid), 16'd1);
    for (int s = 0; s < stall; s++) begin
      idReady = 1'b0;
      tick();
      checkOutput("stall_valid", 16'(idValid), 16'd1);
      checkOutput("stall_idpc",  16'(idPc),    16'(modelIdPc));
      checkOutput("stall_req",   16'(imemReq), 16'd0);
      checkFields("stall", modelIr);
    end
    idReady = 1'b1; brTaken = branch; brTarget = tgt;
    tick();
    idReady = 1'b0; brTaken = 1'b0;
    checkOutput("post_accept_valid", 16'(idValid), 16'd0);
    if (branch) modelPc = int'(tgt);
    if (!branch && ((int'(modelIr) >> 12) == 15)) begin
      checkOutput("halt_halted", 16'(halted),  16'd1);
      checkOutput("halt_req",    16'(imemReq), 16'd0);
    end else begin
      checkOutput("next_halted", 16'(halted),   16'd0);
      checkOutput("next_req",    16'(imemReq),  16'd1);
      checkOutput("next_addr",   16'(imemAddr), 16'(modelPc));
    end
  endtask

  // Random traffic: random memory latency, stalls and redirects.
  task automatic applyStimulus(input int count);
    int w, brA, brB, st;
    bit dropped;
    for (int i = 0; i < count; i++) begin
      w = $urandom_range(0, 3);
      brA = -1; brB = -1;
      if ($urandom_range(0, 4) == 0) begin
        brA = $urandom_range(0, w);
        if ($urandom_range(0, 2) == 0) brB = $urandom_range(brA, w);
      end
      fetchStep(w, brA, 8'($urandom_range(0, 255)), brB, 8'($urandom_range(0, 255)), dropped);
      if (!dropped) begin
        st = $urandom_range(0, 3);
        acceptStep(st, ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 255)));
      end
    end
  endtask

  initial begin
    logic [15:0] rw;
    bit dropped;
    rst = 1'b1; imemReady = 1'b0; imemRdata = 16'h0; idReady = 1'b0;
    brTaken = 1'b0; brTarget = 8'h0;
    for (int i = 0; i < 256; i++) begin
      rw = 16'($urandom);
      if (rw[15:12] == 4'hF) rw[15:12] = 4'hE;
      mem[i] = rw;
    end
    mem[0] = 16'h1123; mem[1] = 16'h8456; mem[2] = 16'h9789;
    mem[5] = 16'h3A5C; mem[6] = 16'h8ABC;

    $display("[TB] zero-wait program 0..2");
    resetDut();
    for (int i = 0; i < 3; i++) begin
      fetchStep(0, -1, 8'h0, -1, 8'h0, dropped);
      acceptStep(0, 1'b0, 8'h0);
    end

    $display("[TB] delayed ready at 0x05");
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);
    fetchStep(3, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);

    $display("[TB] downstream stall on opcode 8");
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(5, 1'b0, 8'h0);

    $display("[TB] redirect during outstanding fetch");
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b1, 8'h10);
    fetchStep(2, 1, 8'h40, -1, 8'h0, dropped);
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);
    fetchStep(3, 0, 8'h55, 2, 8'h66, dropped);
    fetchStep(1, -1, 8'h0, -1, 8'h0, dropped); acceptStep(1, 1'b0, 8'h0);
    fetchStep(1, 1, 8'h77, -1, 8'h0, dropped);
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);

    $display("[TB] random traffic");
    applyStimulus(40);

    $display("[TB] wrap and halt");
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped);
    mem[8'h00] = 16'hF000; mem[8'h20] = 16'hF123;
    acceptStep(0, 1'b1, 8'hFF);
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);
    checkOutput("wrap_pc", 16'(imemAddr), 16'h0000);
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b1, 8'h20);
    fetchStep(1, -1, 8'h0, -1, 8'h0, dropped); acceptStep(2, 1'b0, 8'h0);
    for (int c = 0; c < 20; c++) begin
      brTaken = (c == 5); brTarget = 8'h33;
      idReady = 1'($urandom_range(0, 1));
      imemReady = 1'($urandom_range(0, 1));
      tick();
      brTaken = 1'b0;
      checkOutput("halt_hold_halted", 16'(halted),  16'd1);
      checkOutput("halt_hold_req",    16'(imemReq), 16'd0);
      checkOutput("halt_hold_valid",  16'(idValid), 16'd0);
    end
    imemReady = 1'b0; idReady = 1'b0;

    $display("[TB] reset in the middle of a fetch");
    mem[0] = 16'h2345;
    resetDut();
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);
    imemReady = 1'b0;
    tick();
    checkOutput("midreq_addr", 16'(imemAddr), 16'd1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_req",   16'(imemReq),  16'd0);
    checkOutput("midrst_valid", 16'(idValid),  16'd0);
    checkOutput("midrst_pc",    16'(imemAddr), 16'd0);
    imemReady = 1'b1; imemRdata = 16'h7777;
    tick();
    checkOutput("late_ready_req",   16'(imemReq), 16'd0);
    checkOutput("late_ready_valid", 16'(idValid), 16'd0);
    checkOutput("late_ready_ir",    16'(idOpcode), 16'd0);
    imemReady = 1'b0; rst = 1'b0;
    modelPc = 0; modelIr = 16'h0;
    tick();
    checkOutput("restart_req",  16'(imemReq),  16'd1);
    checkOutput("restart_addr", 16'(imemAddr), 16'd0);
    fetchStep(0, -1, 8'h0, -1, 8'h0, dropped); acceptStep(0, 1'b0, 8'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
